// File: rtl/lfsr_pkg.sv
// Shared definitions for the range-limited LFSR generator: feedback modes,
// request FSM states, the maximal-length tap table and SAFE/lockup helpers.
package lfsr_pkg;

    localparam int MODE_XNOR = 0;
    localparam int MODE_XOR  = 1;
    localparam int MAX_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_HOLD   = 2'd2
    } req_state_t;

    // Bit k set means state bit k is a feedback tap; the MSB is always tapped.
    function automatic logic [MAX_WIDTH-1:0] tap_mask(input int width);
        logic [MAX_WIDTH-1:0] mask;
        case (width)
            3:       mask = 16'h0006;
            4:       mask = 16'h000C;
            5:       mask = 16'h0014;
            6:       mask = 16'h0030;
            7:       mask = 16'h0060;
            8:       mask = 16'h00B8;
            9:       mask = 16'h0110;
            10:      mask = 16'h0240;
            11:      mask = 16'h0500;
            12:      mask = 16'h0829;
            13:      mask = 16'h100D;
            14:      mask = 16'h2015;
            15:      mask = 16'h6000;
            16:      mask = 16'hD008;
            default: mask = 16'h0000;
        endcase
        return mask;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] lockup_value(input int width, input int mode);
        logic [MAX_WIDTH-1:0] value;
        if (mode == MODE_XNOR) begin
            value = 16'hFFFF >> (MAX_WIDTH - width);
        end else begin
            value = 16'h0000;
        end
        return value;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] safe_value(input int mode);
        logic [MAX_WIDTH-1:0] value;
        value = (mode == MODE_XOR) ? 16'h0001 : 16'h0000;
        return value;
    endfunction

endpackage

// File: rtl/lfsr_range_gen_core.sv
// Fibonacci LFSR core: seed load, lockup recovery and wrap detection against
// the most recently loaded value.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MODE  = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] lfsr_out,
    output logic             wrap,
    output logic             lockup
);

    localparam logic [MAX_WIDTH-1:0] TAPS_FULL = tap_mask(WIDTH);
    localparam logic [MAX_WIDTH-1:0] LOCK_FULL = lockup_value(WIDTH, MODE);
    localparam logic [MAX_WIDTH-1:0] SAFE_FULL = safe_value(MODE);
    localparam logic [WIDTH-1:0]     TAPS      = TAPS_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]     LOCK      = LOCK_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]     SAFE      = SAFE_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] wrap_ref;
    logic [WIDTH-1:0] step_value;
    logic [WIDTH-1:0] seed_fixed;
    logic             fb;

    // A seed equal to the lockup state would freeze the register, so swap in SAFE.
    always_comb begin
        fb         = (MODE == MODE_XOR) ? ^(state & TAPS) : ~^(state & TAPS);
        step_value = {state[WIDTH-2:0], fb};
        seed_fixed = (seed == LOCK) ? SAFE : seed;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= SAFE;
            wrap_ref <= SAFE;
            wrap     <= 1'b0;
            lockup   <= 1'b0;
        end else begin
            wrap   <= 1'b0;
            lockup <= 1'b0;
            if (load) begin
                state    <= seed_fixed;
                wrap_ref <= seed_fixed;
            end else if (state == LOCK) begin
                state  <= seed_fixed;
                lockup <= 1'b1;
            end else if (enable) begin
                state <= step_value;
                wrap  <= (step_value == wrap_ref);
            end
        end
    end

    assign lfsr_out = state;

endmodule

// File: rtl/lfsr_range_gen.sv
// Request front end: draws LFSR values until one falls below the captured
// limit or the try budget runs out, then holds the answer until acknowledged.
module lfsr_range_gen
    import lfsr_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MODE      = 0,
    parameter int MAX_TRIES = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] limit,
    input  logic             req,
    input  logic             rsp_ack,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_value,
    output logic             rsp_err,
    output logic [WIDTH-1:0] lfsr_out,
    output logic             wrap,
    output logic             lockup
);

    localparam int               TRY_W    = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    req_state_t       state;
    req_state_t       next_state;
    logic [WIDTH-1:0] limit_q;
    logic [TRY_W-1:0] tries;
    logic             in_range;
    logic             exhausted;
    logic             accept;
    logic             hit;
    logic             miss;
    logic             ack_taken;

    lfsr_core #(
        .WIDTH (WIDTH),
        .MODE  (MODE)
    ) u_core (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .load     (load),
        .seed     (seed),
        .lfsr_out (lfsr_out),
        .wrap     (wrap),
        .lockup   (lockup)
    );

    assign in_range  = (lfsr_out < limit_q);
    assign exhausted = (tries == LAST_TRY);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    next_state = (limit == '0) ? ST_HOLD : ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (enable && (in_range || exhausted)) begin
                    next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (rsp_ack) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        rsp_valid = (state == ST_HOLD);
        accept    = (state == ST_IDLE) && req;
        hit       = (state == ST_SEARCH) && enable && in_range;
        miss      = (state == ST_SEARCH) && enable && !in_range;
        ack_taken = (state == ST_HOLD) && rsp_ack;
    end

    // Response fields are cleared on acknowledge so a stale answer never lingers.
    always_ff @(posedge clock) begin
        if (reset) begin
            limit_q   <= '0;
            tries     <= '0;
            rsp_value <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            limit_q   <= limit;
            tries     <= '0;
            rsp_value <= '0;
            rsp_err   <= (limit == '0);
        end else if (hit) begin
            rsp_value <= lfsr_out;
            rsp_err   <= 1'b0;
        end else if (miss) begin
            tries <= tries + 1'b1;
            if (exhausted) begin
                rsp_value <= '0;
                rsp_err   <= 1'b1;
            end
        end else if (ack_taken) begin
            rsp_value <= '0;
            rsp_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lfsr_range_gen.sv
// Self-checking bench for lfsr_range_gen: directed vectors at WIDTH 3 and 8,
// then randomized traffic at WIDTH 5 against an arithmetic reference model.
module tb_lfsr_range_gen;

    localparam int PH_IDLE     = 0;
    localparam int PH_SEARCH   = 1;
    localparam int PH_HOLD     = 2;
    localparam int R_MAX_TRIES = 6;
    localparam int R_LOCK      = 31;
    localparam int R_CYCLES    = 2000;

    logic clock;
    int   compared;
    int   mismatched;

    logic       rst3, en3, ld3, req3, ack3;
    logic [2:0] seed3, lim3, lfsr3, value3;
    logic       wrap3, lock3, valid3, err3;

    logic       rst8, en8, ld8, req8, ack8;
    logic [7:0] seed8, lim8, lfsr8, value8;
    logic       wrap8, lock8, valid8, err8;

    logic       rstR, enR, ldR, reqR, ackR;
    logic [4:0] seedR, limR, lfsrR, valueR;
    logic       wrapR, lockR, validR, errR;

    int   mLfsr, mRef, mPhase, mLimit, mTries, mValue, mErr;
    logic mWrap, mLock;

    typedef struct {
        logic       enable;
        logic       load;
        logic [2:0] seed;
        logic [2:0] expLfsr;
        logic       expWrap;
        logic       expLockup;
    } vec_t;

    vec_t vecs[19];

    lfsr_range_gen #(.WIDTH(3), .MODE(0), .MAX_TRIES(16)) dut3 (
        .clock(clock), .reset(rst3), .enable(en3), .load(ld3), .seed(seed3),
        .limit(lim3), .req(req3), .rsp_ack(ack3), .rsp_valid(valid3),
        .rsp_value(value3), .rsp_err(err3), .lfsr_out(lfsr3), .wrap(wrap3),
        .lockup(lock3)
    );

    lfsr_range_gen #(.WIDTH(8), .MODE(1), .MAX_TRIES(2)) dut8 (
        .clock(clock), .reset(rst8), .enable(en8), .load(ld8), .seed(seed8),
        .limit(lim8), .req(req8), .rsp_ack(ack8), .rsp_valid(valid8),
        .rsp_value(value8), .rsp_err(err8), .lfsr_out(lfsr8), .wrap(wrap8),
        .lockup(lock8)
    );

    lfsr_range_gen #(.WIDTH(5), .MODE(0), .MAX_TRIES(R_MAX_TRIES)) dutR (
        .clock(clock), .reset(rstR), .enable(enR), .load(ldR), .seed(seedR),
        .limit(limR), .req(reqR), .rsp_ack(ackR), .rsp_valid(validR),
        .rsp_value(valueR), .rsp_err(errR), .lfsr_out(lfsrR), .wrap(wrapR),
        .lockup(lockR)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic applyStimulus();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // x^5 + x^3 + 1 in XNOR form: feedback is the inverted parity of bits 4 and 2.
    function automatic int stepModel(input int s);
        int ones;
        ones = ((s >> 4) & 1) + ((s >> 2) & 1);
        return ((s * 2) % 32) + (1 - (ones % 2));
    endfunction

    task automatic modelCycle();
        int cur;
        int seedFixed;
        cur = mLfsr;
        if (rstR) begin
            mLfsr = 0; mRef = 0; mWrap = 1'b0; mLock = 1'b0;
            mPhase = PH_IDLE; mLimit = 0; mTries = 0; mValue = 0; mErr = 0;
            return;
        end
        seedFixed = (int'(seedR) == R_LOCK) ? 0 : int'(seedR);
        mWrap = 1'b0;
        mLock = 1'b0;
        if (ldR) begin
            mLfsr = seedFixed;
            mRef  = seedFixed;
        end else if (cur == R_LOCK) begin
            mLfsr = seedFixed;
            mLock = 1'b1;
        end else if (enR) begin
            mLfsr = stepModel(cur);
            mWrap = (mLfsr == mRef);
        end
        if (mPhase == PH_IDLE) begin
            if (reqR) begin
                mLimit = int'(limR);
                mTries = 0;
                mValue = 0;
                mErr   = (mLimit == 0) ? 1 : 0;
                mPhase = (mLimit == 0) ? PH_HOLD : PH_SEARCH;
            end
        end else if (mPhase == PH_SEARCH) begin
            if (enR) begin
                if (cur < mLimit) begin
                    mValue = cur;
                    mErr   = 0;
                    mPhase = PH_HOLD;
                end else begin
                    mTries++;
                    if (mTries == R_MAX_TRIES) begin
                        mValue = 0;
                        mErr   = 1;
                        mPhase = PH_HOLD;
                    end
                end
            end
        end else if (ackR) begin
            mPhase = PH_IDLE;
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst3 = 1'b1; en3 = 1'b0; ld3 = 1'b0; req3 = 1'b0; ack3 = 1'b0; seed3 = '0; lim3 = '0;
        rst8 = 1'b1; en8 = 1'b0; ld8 = 1'b0; req8 = 1'b0; ack8 = 1'b0; seed8 = '0; lim8 = '0;
        rstR = 1'b1; enR = 1'b0; ldR = 1'b0; reqR = 1'b0; ackR = 1'b0; seedR = '0; limR = '0;

        vecs[0]  = '{1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 3'b001, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'b000, 3'b011, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 3'b000, 3'b110, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 3'b000, 3'b101, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 3'b000, 3'b100, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 3'b000, 3'b001, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 3'b010, 3'b010, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 3'b000, 3'b100, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 3'b000, 3'b100, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 3'b000, 3'b001, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 3'b000, 3'b011, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 3'b000, 3'b110, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 3'b000, 3'b101, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 3'b000, 3'b010, 1'b1, 1'b0};

        applyStimulus();
        checkOutput("reset_lfsr3", 32'(lfsr3), 0);
        checkOutput("reset_wrap3", 32'(wrap3), 0);
        checkOutput("reset_lock3", 32'(lock3), 0);
        checkOutput("reset_valid3", 32'(valid3), 0);
        checkOutput("reset_value3", 32'(value3), 0);
        checkOutput("reset_err3", 32'(err3), 0);
        checkOutput("reset_lfsr8", 32'(lfsr8), 1);
        checkOutput("reset_valid8", 32'(valid8), 0);
        rst3 = 1'b0;
        rst8 = 1'b0;

        for (int i = 0; i < 19; i++) begin
            en3   = vecs[i].enable;
            ld3   = vecs[i].load;
            seed3 = vecs[i].seed;
            applyStimulus();
            checkOutput($sformatf("vec%0d_lfsr", i), 32'(lfsr3), 32'(vecs[i].expLfsr));
            checkOutput($sformatf("vec%0d_wrap", i), 32'(wrap3), 32'(vecs[i].expWrap));
            checkOutput($sformatf("vec%0d_lockup", i), 32'(lock3), 32'(vecs[i].expLockup));
        end

        // Lockup recovery: the state can only reach 111 by being forced there.
        en3 = 1'b0; ld3 = 1'b0; seed3 = 3'b111;
        force dut3.u_core.state = 3'b111;
        #2;
        release dut3.u_core.state;
        applyStimulus();
        checkOutput("lockup_pulse_safe", 32'(lock3), 1);
        checkOutput("lockup_lfsr_safe", 32'(lfsr3), 0);
        applyStimulus();
        checkOutput("lockup_one_cycle", 32'(lock3), 0);
        seed3 = 3'b101;
        force dut3.u_core.state = 3'b111;
        #2;
        release dut3.u_core.state;
        applyStimulus();
        checkOutput("lockup_pulse_seed", 32'(lock3), 1);
        checkOutput("lockup_lfsr_seed", 32'(lfsr3), 5);

        // Best-case latency: seed 001 loaded alongside the request.
        ld3 = 1'b1; seed3 = 3'b001; req3 = 1'b1; lim3 = 3'd4; en3 = 1'b0;
        applyStimulus();
        checkOutput("lat_n1_valid", 32'(valid3), 0);
        checkOutput("lat_n1_lfsr", 32'(lfsr3), 1);
        ld3 = 1'b0; req3 = 1'b0; en3 = 1'b1;
        applyStimulus();
        checkOutput("lat_n2_valid", 32'(valid3), 1);
        checkOutput("lat_n2_value", 32'(value3), 1);
        checkOutput("lat_n2_err", 32'(err3), 0);
        req3 = 1'b1; lim3 = 3'd0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput($sformatf("hold%0d_valid", i), 32'(valid3), 1);
            checkOutput($sformatf("hold%0d_value", i), 32'(value3), 1);
        end
        req3 = 1'b0; ack3 = 1'b1;
        applyStimulus();
        checkOutput("ack_valid", 32'(valid3), 0);
        ack3 = 1'b0;

        req3 = 1'b1; lim3 = 3'd0;
        applyStimulus();
        checkOutput("zero_limit_valid", 32'(valid3), 1);
        checkOutput("zero_limit_err", 32'(err3), 1);
        checkOutput("zero_limit_value", 32'(value3), 0);
        req3 = 1'b0; ack3 = 1'b1;
        applyStimulus();
        checkOutput("zero_limit_ack", 32'(valid3), 0);
        ack3 = 1'b0;

        // Load during SEARCH: the search carries on from the loaded state.
        req3 = 1'b1; lim3 = 3'd1; ld3 = 1'b1; seed3 = 3'b100; en3 = 1'b0;
        applyStimulus();
        checkOutput("mid_load_search", 32'(valid3), 0);
        req3 = 1'b0; ld3 = 1'b1; seed3 = 3'b000; en3 = 1'b1;
        applyStimulus();
        checkOutput("mid_load_miss", 32'(valid3), 0);
        checkOutput("mid_load_lfsr", 32'(lfsr3), 0);
        ld3 = 1'b0;
        applyStimulus();
        checkOutput("mid_load_valid", 32'(valid3), 1);
        checkOutput("mid_load_value", 32'(value3), 0);
        checkOutput("mid_load_err", 32'(err3), 0);
        ack3 = 1'b1;
        applyStimulus();
        ack3 = 1'b0;

        // Reset beats a simultaneous load while a search is stalled.
        req3 = 1'b1; lim3 = 3'd2; ld3 = 1'b1; seed3 = 3'b110; en3 = 1'b0;
        applyStimulus();
        req3 = 1'b0; ld3 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus();
            checkOutput($sformatf("stall%0d_valid", i), 32'(valid3), 0);
            checkOutput($sformatf("stall%0d_lfsr", i), 32'(lfsr3), 6);
        end
        rst3 = 1'b1; ld3 = 1'b1; seed3 = 3'b101;
        applyStimulus();
        checkOutput("reset_load_lfsr", 32'(lfsr3), 0);
        checkOutput("reset_load_valid", 32'(valid3), 0);
        rst3 = 1'b0; ld3 = 1'b0; en3 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus();
            checkOutput($sformatf("post_reset%0d_valid", i), 32'(valid3), 0);
        end

        // WIDTH 8 XOR: limit 1 can never hit because the state is never zero.
        req8 = 1'b1; lim8 = 8'd1; en8 = 1'b1;
        applyStimulus();
        checkOutput("tries_accept_valid", 32'(valid8), 0);
        req8 = 1'b0;
        applyStimulus();
        checkOutput("tries_first_valid", 32'(valid8), 0);
        en8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput($sformatf("tries_stall%0d_valid", i), 32'(valid8), 0);
        end
        en8 = 1'b1;
        applyStimulus();
        checkOutput("tries_exhaust_valid", 32'(valid8), 1);
        checkOutput("tries_exhaust_err", 32'(err8), 1);
        checkOutput("tries_exhaust_value", 32'(value8), 0);
        ack8 = 1'b1; en8 = 1'b0;
        applyStimulus();
        checkOutput("tries_ack_valid", 32'(valid8), 0);
        ack8 = 1'b0;
        ld8 = 1'b1; seed8 = 8'h00;
        applyStimulus();
        checkOutput("xor_lockup_seed_lfsr", 32'(lfsr8), 1);
        checkOutput("xor_lockup_seed_pulse", 32'(lock8), 0);
        seed8 = 8'h10; req8 = 1'b1; lim8 = 8'h20;
        applyStimulus();
        ld8 = 1'b0; req8 = 1'b0; en8 = 1'b1;
        applyStimulus();
        checkOutput("w8_hit_valid", 32'(valid8), 1);
        checkOutput("w8_hit_value", 32'(value8), 32'h10);
        checkOutput("w8_hit_err", 32'(err8), 0);

        // Randomized traffic on the WIDTH 5 instance against the model.
        rstR = 1'b1;
        modelCycle();
        applyStimulus();
        for (int c = 0; c < R_CYCLES; c++) begin
            rstR  = ($urandom_range(0, 63) == 0);
            enR   = ($urandom_range(0, 3) != 0);
            ldR   = ($urandom_range(0, 15) == 0);
            reqR  = ($urandom_range(0, 1) == 1);
            ackR  = ($urandom_range(0, 2) == 0);
            seedR = 5'($urandom_range(0, 31));
            limR  = 5'($urandom_range(0, 31));
            modelCycle();
            applyStimulus();
            checkOutput("rnd_lfsr", 32'(lfsrR), mLfsr);
            checkOutput("rnd_wrap", 32'(wrapR), 32'(mWrap));
            checkOutput("rnd_lockup", 32'(lockR), 32'(mLock));
            checkOutput("rnd_valid", 32'(validR), (mPhase == PH_HOLD) ? 1 : 0);
            if (mPhase == PH_HOLD) begin
                checkOutput("rnd_value", 32'(valueR), mValue);
                checkOutput("rnd_err", 32'(errR), mErr);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lfsr_range_gen.md
LFSR_RANGE_GEN -- requirements
Module: lfsr_range_gen

Interface
REQ-001 Parameter WIDTH, default 8: LFSR width, legal range 3..16.
REQ-002 Parameter MODE, default 0: feedback mode; 0 = XNOR (lockup state all-ones), 1 = XOR (lockup state all-zeros).
REQ-003 Parameter MAX_TRIES, default 16: maximum enabled steps spent searching for one in-range value.
REQ-004 Port clock  input  1  rising-edge clock for all state.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port enable  input  1  advances the LFSR one step per cycle when high.
REQ-007 Port load  input  1  loads seed into the LFSR this cycle.
REQ-008 Port seed  input  WIDTH  value applied by load and by lockup recovery.
REQ-009 Port limit  input  WIDTH  exclusive upper bound for a request, sampled when req is accepted.
REQ-010 Port req  input  1  request for one random value in [0, limit).
REQ-011 Port rsp_ack  input  1  consumer acknowledge of the response.
REQ-012 Port rsp_valid  output  1  response held until acknowledged.
REQ-013 Port rsp_value  output  WIDTH  returned value; 0 when rsp_err is high.
REQ-014 Port rsp_err  output  1  request failed (limit 0 or MAX_TRIES exhausted).
REQ-015 Port lfsr_out  output  WIDTH  current LFSR state.
REQ-016 Port wrap  output  1  one-cycle pulse when a step returns the state to the last loaded value.
REQ-017 Port lockup  output  1  one-cycle pulse when lockup recovery fires.

Function
REQ-018 The LFSR is Fibonacci: next = {lfsr_out[WIDTH-2:0], fb}; fb is the XNOR (MODE 0) or XOR (MODE 1) reduction of the tap bits, with taps taken from the maximal-length package table indexed by WIDTH.
REQ-019 Priority per cycle: reset, then load, then lockup recovery, then the enable step.
REQ-020 Load sets lfsr_out to seed, or to SAFE when seed equals the lockup state; SAFE is 0 for MODE 0 and 1 for MODE 1. Load also records that value as the wrap reference.
REQ-021 Lockup recovery: if lfsr_out equals the lockup state, the next edge loads seed, or SAFE when seed is itself the lockup state, regardless of enable, and pulses lockup for one cycle.
REQ-022 wrap pulses in the cycle after an enabled step whose result equals the wrap reference; it does not pulse on load itself.
REQ-023 Request FSM states are IDLE, SEARCH and HOLD.
REQ-024 IDLE: req=1 captures limit and clears the try counter. If limit=0, go to HOLD with rsp_err=1; otherwise go to SEARCH.
REQ-025 SEARCH, each cycle with enable=1: if lfsr_out < captured limit, latch rsp_value=lfsr_out and go to HOLD. Otherwise increment the try counter; when it reaches MAX_TRIES, go to HOLD with rsp_err=1 and rsp_value=0.
REQ-026 SEARCH with enable=0 stalls; the try counter does not advance.
REQ-027 HOLD: rsp_valid=1, with rsp_value and rsp_err stable. rsp_ack=1 returns to IDLE in the next cycle. req is ignored outside IDLE.
REQ-028 Best-case latency: req at cycle N, rsp_valid high at cycle N+2 when the first sampled value is in range.
REQ-029 A load during SEARCH is legal; the search continues on the new state without restarting the try counter.
REQ-030 Comparisons are unsigned at WIDTH bits; the try counter is clog2(MAX_TRIES+1) bits wide.

Reset
REQ-031 reset drives lfsr_out=SAFE, wrap reference=SAFE, FSM=IDLE, rsp_valid=0, rsp_value=0, rsp_err=0, wrap=0, lockup=0 and try counter=0.
REQ-032 reset mid-SEARCH or mid-HOLD abandons the request; no response is produced afterwards.

Structure
REQ-033 Package lfsr_pkg holds the tap-mask table for WIDTH 3..16, the MODE constants and the SAFE/lockup helper functions.
REQ-034 One sub-module, lfsr_core, contains the LFSR, load, lockup recovery and wrap logic; lfsr_range_gen adds the request FSM.

Verification
REQ-035 WIDTH=3, MODE=0, load seed 000, enable held -> lfsr_out sequence 001,011,110,101,010,100,000; wrap pulses after the 7th step.
REQ-036 WIDTH=3, MODE=0, load seed 111 -> lfsr_out=000, no lockup pulse; force the internal state to 111 -> lockup pulses and lfsr_out=SAFE the next cycle.
REQ-037 WIDTH=3, state 001, req with limit=4, enable=1 -> rsp_valid at N+2 with rsp_value=1, rsp_err=0; held until rsp_ack.
REQ-038 req with limit=0 -> rsp_valid with rsp_err=1 and rsp_value=0 in the next cycle.
REQ-039 WIDTH=8, MAX_TRIES=2, limit=1, state never 0 -> rsp_err=1 after 2 enabled search cycles.
REQ-040 Simultaneous reset and load mid-SEARCH -> reset wins: lfsr_out=SAFE, FSM=IDLE, rsp_valid never asserts.
